// File: rtl/div_sequencer.sv
// rtl/div_sequencer.sv - multi-cycle DIV/DIVU sequencer for the shared HI/LO unit
//
// Radix-2 restoring divider that retires one quotient bit per cycle. It holds
// IF..EX stalled while it works and then issues a single HI/LO write strobe.
//
// Build option: define DIV_EARLY_OUT_EN to skip the iterations when |a| < |b|
// (the quotient is then zero and the remainder is the dividend).
//
// Ports:
//   clk, rst     pipeline clock, synchronous active-high reset
//   start        divide valid in EX, held high while the pipeline is stalled
//   signed_div   1 = DIV, 0 = DIVU (sampled with start)
//   annul        EX flush; cancels any operation in flight
//   ext_stall    pipeline frozen by another source; delays the HI/LO write
//   src_a, src_b dividend (rs) and divisor (rt)
//   stall        freeze request for IF..EX
//   hilo_we      one-cycle HI/LO write strobe; hi/lo take the new result on this edge
//   hi, lo       remainder and quotient, held between operations
//   busy         sequencer not idle

module div_sequencer #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             signed_div,
  input  logic             annul,
  input  logic             ext_stall,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  output logic             stall,
  output logic             hilo_we,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t stateQ, stateD;

  logic [CNT_W-1:0] counter;
  logic [WIDTH-1:0] divisor;
  logic [WIDTH-1:0] dvd;      // dividend shifts out of the top, quotient bits shift in
  logic [WIDTH-1:0] rem;
  logic [WIDTH-1:0] rawA;     // unmodified dividend, returned as HI on divide by zero
  logic             qNeg;
  logic             rNeg;
  logic             divZero;

  logic             aNeg, bNeg, accept, lastIter, earlyOut, commit;
  logic [WIDTH-1:0] absA, absB, hiRes, loRes;
  logic [WIDTH:0]   remShift, trial;

  assign aNeg   = signed_div & src_a[WIDTH-1];
  assign bNeg   = signed_div & src_b[WIDTH-1];
  assign absA   = aNeg ? -src_a : src_a;
  assign absB   = bNeg ? -src_b : src_b;
  assign accept = (stateQ == IDLE) & start & !annul;

`ifdef DIV_EARLY_OUT_EN
  assign earlyOut = (absA < absB) && (src_b != '0);
`else
  assign earlyOut = 1'b0;
`endif

  // rem < divisor always holds, so the shifted remainder fits in WIDTH+1 bits
  // and a non-negative trial difference fits back into WIDTH bits.
  assign remShift = {rem, dvd[WIDTH-1]};
  assign trial    = remShift - {1'b0, divisor};
  assign lastIter = (counter == CNT_W'(WIDTH - 1));

  // Divide by zero bypasses sign correction entirely.
  assign loRes = divZero ? '1   : (qNeg ? -dvd : dvd);
  assign hiRes = divZero ? rawA : (rNeg ? -rem : rem);

  assign busy = (stateQ != IDLE);

  always_comb begin
    stateD  = stateQ;
    stall   = 1'b0;
    commit  = 1'b0;
    case (stateQ)
      IDLE: begin
        if (accept) begin
          stall  = 1'b1;
          stateD = earlyOut ? DONE : BUSY;
        end
      end
      BUSY: begin
        stall = 1'b1;
        if (annul)         stateD = IDLE;
        else if (lastIter) stateD = DONE;
      end
      DONE: begin
        // annul wins over the write; ext_stall parks here with results stable
        if (annul) begin
          stateD = IDLE;
        end else if (!ext_stall) begin
          commit = 1'b1;
          stateD = IDLE;
        end
      end
      default: stateD = IDLE;
    endcase
  end

  // Reset must also suppress a strobe that would otherwise fire this cycle.
  assign hilo_we = commit & !rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      stateQ  <= IDLE;
      counter <= '0;
      hi      <= '0;
      lo      <= '0;
      divisor <= '0;
      dvd     <= '0;
      rem     <= '0;
      rawA    <= '0;
      qNeg    <= 1'b0;
      rNeg    <= 1'b0;
      divZero <= 1'b0;
    end else begin
      stateQ <= stateD;
      case (stateQ)
        IDLE: begin
          if (accept) begin
            divisor <= absB;
            rawA    <= src_a;
            qNeg    <= (src_a[WIDTH-1] ^ src_b[WIDTH-1]) & signed_div;
            rNeg    <= aNeg;
            divZero <= (src_b == '0);
            counter <= '0;
            // Early out lands in DONE with quotient 0 and remainder |a|;
            // rNeg restores the dividend's own sign.
            dvd     <= earlyOut ? '0 : absA;
            rem     <= earlyOut ? absA : '0;
          end
        end
        BUSY: begin
          counter <= counter + CNT_W'(1);
          rem     <= trial[WIDTH] ? remShift[WIDTH-1:0] : trial[WIDTH-1:0];
          dvd     <= {dvd[WIDTH-2:0], ~trial[WIDTH]};
        end
        DONE: begin
          if (commit) begin
            hi <= hiRes;
            lo <= loRes;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/div_sequencer.md
Name: div_sequencer

Overview:
- Multi-cycle controller for the shared HI/LO divide resource of the 5-stage MIPS pipeline.
- Accepts DIV/DIVU from the execute stage and runs a radix-2 restoring divide, one quotient bit per cycle.
- Holds the pipeline stalled while busy, then issues one HI/LO write.
- Sits beside the execute-stage ALU; its stall output is ORed into the hazard unit.

Parameters:
- WIDTH, 32, operand/result width in bits.
- CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
- clk  input  1  pipeline clock
- rst  input  1  synchronous active-high reset
- start  input  1  divide instruction valid in EX (isDivE); held high while the pipeline is stalled
- signed_div  input  1  1 = DIV, 0 = DIVU; sampled with start
- annul  input  1  flush of EX (exception/branch squash); cancels any operation
- ext_stall  input  1  pipeline frozen by another source
- src_a  input  WIDTH  dividend (rs)
- src_b  input  WIDTH  divisor (rt)
- stall  output  1  request to freeze IF..EX
- hilo_we  output  1  one-cycle write strobe for HI/LO
- hi  output  WIDTH  remainder
- lo  output  WIDTH  quotient
- busy  output  1  state != IDLE

Behaviour:
- Reset is synchronous and active-high: on rst, state = IDLE, counter = 0, hi = lo = 0, hilo_we = 0; stall and busy evaluate to 0.
- States:
  - IDLE, on start & !annul: latch |src_a|, |src_b|, quotient sign (a[MSB]^b[MSB]) & signed_div, remainder sign a[MSB] & signed_div, signed_div; clear the partial remainder; counter = 0; go to BUSY.
  - BUSY, per cycle: shift {rem, dvd} left 1; trial = rem - divisor (WIDTH+1 bits); if trial is non-negative, rem = trial and the quotient bit = 1, otherwise the quotient bit = 0.
    - counter increments; after WIDTH iterations (counter == WIDTH-1 at the edge), go to DONE.
  - DONE:
    - Apply signs: lo = negate(q) if the quotient sign is set; hi = negate(r) if the remainder sign is set. Two's complement, truncated to WIDTH.
    - hilo_we = 1 for exactly the single cycle in which DONE & !ext_stall, then go to IDLE.
    - While ext_stall = 1, remain in DONE with hilo_we = 0 and results stable.
- stall = (IDLE & start & !annul) | BUSY. It is 0 in DONE, so the divide instruction leaves EX on the same edge that HI/LO is written.
- Latency: start seen in IDLE at cycle 0; stall is high for cycles 0..WIDTH (WIDTH+1 cycles); hilo_we is in cycle WIDTH+1 if there is no ext_stall.
- hi/lo registered; hold their value between operations. Outputs update only in DONE.
- annul in BUSY or DONE returns to IDLE next cycle, with no hilo_we and hi/lo unchanged. annul has priority over hilo_we in the same cycle.
- start in DONE or BUSY is ignored; no restart until IDLE. A back-to-back divide in the cycle after DONE is accepted normally.
- Divide by zero (src_b == 0), both modes: the result is forced to lo = all-ones and hi = src_a (raw), with normal latency. Sign correction is bypassed.
- Most-negative / -1 (signed): lo = 0x80000000, hi = 0 (natural truncation).
- rst in any state overrides everything, including an in-flight hilo_we.

Optional Feature:
- Macro: DIV_EARLY_OUT_EN.
- Defined: in IDLE, if the operands are accepted and |a| < |b| with b != 0, go directly to DONE. The next cycle produces hilo_we (when !ext_stall) with lo = 0 and hi = src_a, sign preserved as given. stall is high for the start cycle only.
- Not defined: all operations take the full WIDTH iterations; no comparator is instantiated.

Test Plan:
- DIVU 100 / 7, no ext_stall -> stall high 33 cycles; then hilo_we pulse with lo=14, hi=2; busy low afterwards.
- DIV -100 / 7 -> lo=0xFFFFFFF2 (-14), hi=0xFFFFFFFE (-2); DIV 100 / -7 -> lo=-14, hi=2.
- DIV 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0. DIVU 5 / 0 -> lo=0xFFFFFFFF, hi=5, normal latency.
- annul asserted at BUSY iteration 10 -> IDLE next cycle, no hilo_we, hi/lo retain prior values. rst asserted mid-BUSY -> all outputs 0 next cycle.
- ext_stall high for 3 cycles on DONE entry -> hilo_we delayed exactly 3 cycles, single pulse, results stable. A back-to-back divide issued the cycle after DONE is accepted.
- With DIV_EARLY_OUT_EN: DIVU 3 / 9 -> hilo_we 1 cycle after start, lo=0, hi=3. Without the macro -> 33-cycle latency, same result.
